// File: rtl/hyper_sched_pkg.sv
// hyper_sched_pkg: shared types and defaults for the HyperBus transaction scheduler
// (defaults mirror ariane_soc: 2 PHYs, 2 chips/PHY, 64 MiB chips, window at 0x8000_0000)
package hyper_sched_pkg;
  localparam int DefNumReq = 2;
  localparam int DefNumPhys = 2;
  localparam int DefNumChips = 2;
  localparam int DefAddrWidth = 32;
  localparam int DefLenWidth = 8;
  localparam int DefMaxBeats = 64;
  localparam logic [63:0] DefChipSize = 64'h400_0000;
  localparam logic [31:0] DefBaseAddr = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic [$clog2(DefNumPhys)-1:0] phy;
    logic [$clog2(DefNumChips)-1:0] cs;
    logic [$clog2(DefChipSize)-1:0] addr;
    logic [DefLenWidth-1:0] len;
    logic write;
    logic [$clog2(DefNumReq)-1:0] id;
  } chunk_t;
endpackage

// File: rtl/hyper_txn_sched_chunk_calc.sv
// hyper_chunk_calc: decodes a window offset to PHY/chip/local address and sizes the next chunk
module hyper_chunk_calc #(
  parameter int AddrWidth = 32,
  parameter int LenWidth = 8,
  parameter logic [63:0] ChipSize = 64'h400_0000,
  parameter int NumChips = 2,
  parameter int NumPhys = 2,
  parameter int MaxBeats = 64,
  localparam int ChipW = $clog2(ChipSize),
  localparam int CsW = $clog2(NumChips),
  localparam int PhyW = $clog2(NumPhys),
  localparam int OffW = AddrWidth + 1
) (
  input  logic [OffW-1:0]     off,
  input  logic [LenWidth:0]   rem,
  output logic [PhyW-1:0]     phy,
  output logic [CsW-1:0]      cs,
  output logic [ChipW-1:0]    addr,
  output logic [LenWidth:0]   beats,
  output logic                err
);
  localparam int BoundW = ChipW - 2;
  localparam int MinW = BoundW > LenWidth + 1 ? BoundW : LenWidth + 1;
  logic [BoundW-1:0] to_bound;
  logic [MinW-1:0] lim, best;
  // beats left before the chip boundary; never zero, so every chunk makes progress
  assign to_bound = BoundW'(ChipSize >> 3) - {1'b0, off[ChipW-1:3]};
  assign lim = MinW'(rem) < MinW'(MaxBeats) ? MinW'(rem) : MinW'(MaxBeats);
  assign best = lim < MinW'(to_bound) ? lim : MinW'(to_bound);
  assign beats = (LenWidth+1)'(best);
  assign addr = off[ChipW-1:0];
  assign cs = off[ChipW +: CsW];
  assign phy = off[ChipW+CsW +: PhyW];
  assign err = |off[OffW-1:ChipW+CsW+PhyW];
endmodule

// File: rtl/hyper_txn_sched.sv
// hyper_txn_sched: round-robin burst scheduler that splits requests into chip-bounded chunks
// and issues them one at a time to the owning HyperBus PHY.
module hyper_txn_sched
  import hyper_sched_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int NumPhys = DefNumPhys,
  parameter int NumChips = DefNumChips,
  parameter logic [63:0] ChipSize = DefChipSize,
  parameter logic [31:0] BaseAddr = DefBaseAddr,
  parameter int AddrWidth = DefAddrWidth,
  parameter int LenWidth = DefLenWidth,
  parameter int MaxBeats = DefMaxBeats,
  localparam int ChipW = $clog2(ChipSize),
  localparam int CsW = $clog2(NumChips),
  localparam int PhyW = $clog2(NumPhys),
  localparam int IdW = $clog2(NumReq),
  localparam int OffW = AddrWidth + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*LenWidth-1:0]    req_len_i,
  input  logic [NumReq-1:0]             req_write_i,
  output logic [NumPhys-1:0]            phy_valid_o,
  input  logic [NumPhys-1:0]            phy_ready_i,
  output logic [ChipW-1:0]              phy_addr_o,
  output logic [CsW-1:0]                phy_cs_o,
  output logic [LenWidth-1:0]           phy_len_o,
  output logic                          phy_write_o,
  input  logic [NumPhys-1:0]            phy_done_i,
  output logic [NumReq-1:0]             done_o,
  output logic [NumReq-1:0]             err_o
);
  state_t state;
  chunk_t chunk;
  logic [IdW-1:0] ptr, win, idx;
  logic any;
  logic [OffW-1:0] off, new_off, c_off;
  logic [LenWidth:0] rem, new_rem, c_rem, c_beats, cur_beats;
  logic [AddrWidth-1:0] new_addr;
  logic [PhyW-1:0] c_phy;
  logic [CsW-1:0] c_cs;
  logic [ChipW-1:0] c_addr;
  logic c_err;
  // first valid requester at or after the pointer, wrapping around
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = IdW'((int'(ptr) + i) % NumReq);
      if (req_valid_i[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign req_ready_o = (!rst_i && state == IDLE && any) ? NumReq'(1) << win : '0;
  assign new_addr = req_addr_i[win*AddrWidth +: AddrWidth];
  assign new_off = {1'b0, new_addr & ~AddrWidth'(7)} - {1'b0, BaseAddr};
  assign new_rem = {1'b0, req_len_i[win*LenWidth +: LenWidth]} + (LenWidth+1)'(1);
  assign c_off = state == IDLE ? new_off : off;
  assign c_rem = state == IDLE ? new_rem : rem;
  assign cur_beats = {1'b0, chunk.len} + (LenWidth+1)'(1);
  hyper_chunk_calc #(
    .AddrWidth(AddrWidth), .LenWidth(LenWidth), .ChipSize(ChipSize),
    .NumChips(NumChips), .NumPhys(NumPhys), .MaxBeats(MaxBeats)
  ) u_calc (
    .off(c_off), .rem(c_rem), .phy(c_phy), .cs(c_cs), .addr(c_addr), .beats(c_beats), .err(c_err)
  );
  assign phy_addr_o = chunk.addr;
  assign phy_cs_o = chunk.cs;
  assign phy_len_o = chunk.len;
  assign phy_write_o = chunk.write;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      off <= '0;
      rem <= '0;
      chunk <= '0;
      phy_valid_o <= '0;
      done_o <= '0;
      err_o <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          chunk <= '{phy: c_phy, cs: c_cs, addr: c_addr, len: LenWidth'(c_beats - (LenWidth+1)'(1)),
                     write: req_write_i[win], id: win};
          off <= new_off;
          rem <= new_rem;
          ptr <= win == IdW'(NumReq - 1) ? '0 : win + IdW'(1);
          if (c_err) begin
            state <= DONE;
            done_o[win] <= 1'b1;
            err_o[win] <= 1'b1;
          end else begin
            state <= ISSUE;
            phy_valid_o[c_phy] <= 1'b1;
          end
        end
        ISSUE: if (phy_ready_i[chunk.phy]) begin
          state <= WAIT;
          phy_valid_o <= '0;
          off <= off + OffW'({cur_beats, 3'b000});
          rem <= rem - cur_beats;
        end
        WAIT: if (phy_done_i[chunk.phy]) begin
          if (rem == '0 || c_err) begin
            state <= DONE;
            done_o[chunk.id] <= 1'b1;
            err_o[chunk.id] <= rem != '0;
          end else begin
            state <= ISSUE;
            chunk.phy <= c_phy;
            chunk.cs <= c_cs;
            chunk.addr <= c_addr;
            chunk.len <= LenWidth'(c_beats - (LenWidth+1)'(1));
            phy_valid_o[c_phy] <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done_o <= '0;
          err_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hyper_txn_sched.sv
// tb_hyper_txn_sched: directed scoreboard bench for the HyperBus transaction scheduler
module tb_hyper_txn_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_write = '0;
  logic [63:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [1:0] phy_valid, phy_ready = '0, phy_done = '0, done, err;
  logic [25:0] phy_addr;
  logic [0:0] phy_cs;
  logic [7:0] phy_len;
  logic phy_write;
  int total = 0, bad = 0;
  typedef struct packed {logic phy; logic cs; logic [25:0] addr; logic [7:0] len; logic w;} chunk_e;
  typedef struct packed {logic id; logic err;} done_e;
  chunk_e cq[$];
  done_e dq[$];
  always #5 clk = ~clk;
  hyper_txn_sched dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_write_i(req_write),
    .phy_valid_o(phy_valid), .phy_ready_i(phy_ready), .phy_addr_o(phy_addr),
    .phy_cs_o(phy_cs), .phy_len_o(phy_len), .phy_write_o(phy_write),
    .phy_done_i(phy_done), .done_o(done), .err_o(err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input int r, input logic [31:0] a, input logic [7:0] l, input logic w);
    req_addr[r*32 +: 32] = a;
    req_len[r*8 +: 8] = l;
    req_write[r] = w;
    req_valid[r] = 1'b1;
  endtask
  task automatic exp_chunk(input logic p, input logic c, input logic [25:0] a, input logic [7:0] l, input logic w);
    cq.push_back('{phy: p, cs: c, addr: a, len: l, w: w});
  endtask
  task automatic exp_done(input logic id, input logic e);
    dq.push_back('{id: id, err: e});
  endtask
  task automatic accept(input int r, input bit hold);
    int n = 0;
    #1;
    while (req_ready === 2'b00 && n < 20) begin
      step();
      #1;
      n++;
    end
    check("grant", req_ready, 32'(1) << r);
    step();
    if (!hold) req_valid[r] = 1'b0;
    check("acc_lat", (|phy_valid) || (|done), 1);
  endtask
  task automatic complete(input int stall);
    int n = 0;
    bit fin = 0;
    chunk_e e;
    done_e d;
    while (!fin && n < 200) begin
      if (|phy_valid) begin
        check("chunk_avail", cq.size() != 0, 1);
        e = cq.size() != 0 ? cq.pop_front() : '0;
        check("valid", phy_valid, 32'(1) << e.phy);
        check("cs", phy_cs, e.cs);
        check("addr", phy_addr, e.addr);
        check("len", phy_len, e.len);
        check("write", phy_write, e.w);
        repeat (stall) begin
          step();
          check("stall_valid", phy_valid, 32'(1) << e.phy);
          check("stall_addr", phy_addr, e.addr);
          check("stall_len", phy_len, e.len);
        end
        stall = 0;
        phy_ready[e.phy] = 1'b1;
        step();
        phy_ready = '0;
        check("drop", phy_valid, 0);
        phy_done[e.phy] = 1'b1;
        step();
        phy_done = '0;
        check("next_lat", (|phy_valid) || (|done), 1);
      end else if (|done) begin
        check("done_avail", dq.size() != 0, 1);
        d = dq.size() != 0 ? dq.pop_front() : '0;
        check("done", done, 32'(1) << d.id);
        check("err", err, d.err ? 32'(1) << d.id : 32'(0));
        check("left", cq.size(), 0);
        fin = 1;
        step();
        check("done_pulse", done, 0);
      end else begin
        step();
        n++;
      end
    end
    check("finished", fin, 1);
  endtask
  initial begin
    step();
    check("rst_out_a", {req_ready, phy_valid, done, err, phy_cs, phy_write}, 0);
    check("rst_out_b", {phy_addr, phy_len}, 0);
    rst = 1'b0;
    step();
    drive(0, 32'h8000_0000, 8'd7, 1'b0);
    exp_chunk(0, 0, 26'h0, 8'd7, 0);
    exp_done(0, 0);
    accept(0, 0);
    complete(0);
    drive(1, 32'h83FF_FFF0, 8'd3, 1'b0);
    exp_chunk(0, 0, 26'h3FF_FFF0, 8'd1, 0);
    exp_chunk(0, 1, 26'h0, 8'd1, 0);
    exp_done(1, 0);
    accept(1, 0);
    complete(0);
    drive(0, 32'h8800_0000, 8'd255, 1'b1);
    for (int i = 0; i < 4; i++) exp_chunk(1, 0, 26'(i * 32'h200), 8'd63, 1);
    exp_done(0, 0);
    accept(0, 0);
    complete(10);
    drive(1, 32'h9000_0000, 8'd0, 1'b0);
    exp_done(1, 1);
    accept(1, 0);
    complete(0);
    drive(0, 32'h7FFF_FFF8, 8'd0, 1'b0);
    exp_done(0, 1);
    accept(0, 0);
    complete(0);
    drive(1, 32'h8FFF_FFF8, 8'd1, 1'b0);
    exp_chunk(1, 1, 26'h3FF_FFF8, 8'd0, 0);
    exp_done(1, 1);
    accept(1, 0);
    complete(0);
    drive(0, 32'h8000_0000, 8'd7, 1'b0);
    accept(0, 0);
    check("pre_rst_valid", phy_valid, 1);
    phy_ready[0] = 1'b1;
    step();
    phy_ready = '0;
    check("in_wait", phy_valid, 0);
    drive(0, 32'h8000_0100, 8'd0, 1'b0);
    drive(1, 32'h8C00_0040, 8'd2, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_a", {req_ready, phy_valid, done, err, phy_cs, phy_write}, 0);
    check("mid_rst_b", {phy_addr, phy_len}, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        exp_chunk(0, 0, 26'h100, 8'd0, 0);
        exp_done(0, 0);
      end else begin
        exp_chunk(1, 1, 26'h40, 8'd2, 1);
        exp_done(1, 0);
      end
      accept(k % 2, 1);
      complete(0);
    end
    req_valid = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
